pc_gen: RTL

Parametrised fetch program-counter generator for the pipelined CPU. It replaces the single hold/load PC register and produces the next fetch address internally: sequential step, taken branch/jump redirect, or function return predicted by a small return-address stack (RAS). Redirects that arrive while the data cache stalls the pipeline are captured and applied later, never dropped. It sits at the head of IF and feeds the instruction memory and IF/ID register.

---
 rtl/pc_gen_pkg.sv | 13 +
 rtl/pc_ras.sv | 70 +++++++
 rtl/pc_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and sizing helpers for the fetch PC generator
package pc_gen_pkg;

    typedef struct packed {
        logic call;
        logic ret;
    } redir_kind_t;

    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with count, push/pop/replace
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pop_i,
    input  logic            push_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int PW = ras_ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [PC_W-1:0] stack_q [DEPTH];
    logic [PW-1:0]   tp_q, tp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic            pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign top_o   = stack_q[tp_q];
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = tp_q;
        if (push_i && pop_ok) begin
            // pop-then-push collapses to overwriting the current top
            wr_en = 1'b1;
        end else if (pop_ok) begin
            tp_d  = tp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end else if (push_i) begin
            tp_d   = tp_q + PW'(1);
            wr_en  = 1'b1;
            wr_idx = tp_q + PW'(1);
            if (!full_o) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                stack_q[wr_idx] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator: step, redirect, RAS return, stall-captured redirects
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               PC_W      = 32,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            hazard_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic [PC_W-1:0] link_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic            redirect_pending_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ras_underflow_o
);

    typedef struct packed {
        logic [PC_W-1:0] target;
        redir_kind_t     kind;
        logic [PC_W-1:0] link;
    } pend_t;

    pend_t           pend_q, pend_d, live, rec;
    logic            pend_v_q, pend_v_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            uf_q, uf_d;
    logic            ras_pop, ras_push, ras_empty, ras_full;
    logic [PC_W-1:0] ras_top;

    assign live = {redirect_pc_i, call_i, ret_i, link_pc_i};
    assign rec  = redirect_i ? live : pend_q;

    always_comb begin
        pc_d     = pc_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        uf_d     = 1'b0;
        ras_pop  = 1'b0;
        ras_push = 1'b0;
        if (start_i) begin
            if (stall_i) begin
                if (redirect_i) begin
                    pend_d   = live;
                    pend_v_d = 1'b1;
                end
            end else if (redirect_i || pend_v_q) begin
                pend_v_d = 1'b0;
                ras_pop  = rec.kind.ret && !ras_empty;
                ras_push = rec.kind.call;
                uf_d     = rec.kind.ret && ras_empty;
                pc_d     = ras_pop ? ras_top : rec.target;
            end else if (!hazard_i) begin
                pc_d = pc_q + PC_W'(STEP);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            uf_q     <= uf_d;
        end
    end

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pop_i       (ras_pop),
        .push_i      (ras_push),
        .push_data_i (rec.link),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    assign pc_o               = pc_q;
    assign redirect_pending_o = pend_v_q;
    assign ras_empty_o        = ras_empty;
    assign ras_full_o         = ras_full;
    assign ras_underflow_o    = uf_q;

endmodule
